// File: rtl/mem_stage.sv
// Memory pipeline stage: byte-addressable data memory with load/store
// alignment checks and sub-word extension, registered toward write-back.
module mem_stage #(
    parameter int DM_WORDS = 1024,
    parameter int IDX_LW   = 0,
    parameter int IDX_SW   = 1,
    parameter int IDX_LB   = 2,
    parameter int IDX_LBU  = 3,
    parameter int IDX_LH   = 4,
    parameter int IDX_LHU  = 5,
    parameter int IDX_SB   = 6,
    parameter int IDX_SH   = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC_EX_to_Mem,
    input  logic [4:0]  RegWriteAddr_EX_to_Mem,
    input  logic [59:0] InstrType_EX_to_Mem,
    input  logic [31:0] ALUOut_EX_to_Mem,
    input  logic [31:0] DMWriteData_EX_to_Mem,
    output logic [31:0] PC_Mem_to_WB,
    output logic [4:0]  RegWriteAddr_Mem_to_WB,
    output logic [59:0] InstrType_Mem_to_WB,
    output logic [31:0] ALUOut_Mem_to_WB,
    output logic [31:0] DMReadData_Mem_to_WB,
    output logic        AddrErr_Mem_to_WB
);

    localparam int AW = $clog2(DM_WORDS);
    localparam logic [31:0] PC_RESET = 32'h0000_3000;

    logic [31:0]   dm_q [DM_WORDS];
    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic [59:0]   itype;
    logic          onehot;
    logic          is_lw, is_sw, is_lb, is_lbu;
    logic          is_lh, is_lhu, is_sb, is_sh;
    logic          is_store, mis, we;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   rword, rshift;
    logic [15:0]   rhalf;
    logic [7:0]    rbyte;

    logic [31:0] pc_q, pc_d;
    logic [4:0]  rwa_q, rwa_d;
    logic [59:0] it_q, it_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] rd_q, rd_d;
    logic        err_q, err_d;

    assign idx   = ALUOut_EX_to_Mem[AW+1:2];
    assign off   = ALUOut_EX_to_Mem[1:0];
    assign itype = InstrType_EX_to_Mem;

    // An ill-formed type bus (zero or several bits) must not touch memory.
    assign onehot = (|itype) && ~|(itype & (itype - 60'd1));

    assign is_lw  = onehot & itype[IDX_LW];
    assign is_sw  = onehot & itype[IDX_SW];
    assign is_lb  = onehot & itype[IDX_LB];
    assign is_lbu = onehot & itype[IDX_LBU];
    assign is_lh  = onehot & itype[IDX_LH];
    assign is_lhu = onehot & itype[IDX_LHU];
    assign is_sb  = onehot & itype[IDX_SB];
    assign is_sh  = onehot & itype[IDX_SH];

    assign is_store = is_sw | is_sh | is_sb;
    assign mis = ((is_lw | is_sw) & (|off))
               | ((is_lh | is_lhu | is_sh) & off[0]);
    assign we  = is_store & ~mis;

    // Byte-lane enables and lane-replicated store data.
    always_comb begin
        be    = 4'b0000;
        wdata = DMWriteData_EX_to_Mem;
        unique case (1'b1)
            is_sw: begin
                be    = 4'b1111;
                wdata = DMWriteData_EX_to_Mem;
            end
            is_sh: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{DMWriteData_EX_to_Mem[15:0]}};
            end
            is_sb: begin
                be    = 4'b0001 << off;
                wdata = {4{DMWriteData_EX_to_Mem[7:0]}};
            end
            default: begin
                be    = 4'b0000;
                wdata = DMWriteData_EX_to_Mem;
            end
        endcase
    end

    assign rword  = dm_q[idx];
    assign rshift = rword >> {off, 3'b000};
    assign rbyte  = rshift[7:0];
    assign rhalf  = off[1] ? rword[31:16] : rword[15:0];

    // Load data selection and extension; zero when not a valid load.
    always_comb begin
        rd_d = 32'd0;
        if (!mis) begin
            unique case (1'b1)
                is_lw:   rd_d = rword;
                is_lb:   rd_d = {{24{rbyte[7]}}, rbyte};
                is_lbu:  rd_d = {24'd0, rbyte};
                is_lh:   rd_d = {{16{rhalf[15]}}, rhalf};
                is_lhu:  rd_d = {16'd0, rhalf};
                default: rd_d = 32'd0;
            endcase
        end
    end

    // Passthrough next-state values.
    always_comb begin
        pc_d  = PC_EX_to_Mem;
        rwa_d = RegWriteAddr_EX_to_Mem;
        it_d  = InstrType_EX_to_Mem;
        alu_d = ALUOut_EX_to_Mem;
        err_d = mis;
    end

    // Data memory: cleared on reset, byte-lane writes on the clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                dm_q[i] <= 32'd0;
            end
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    dm_q[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Mem/WB pipeline register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= PC_RESET;
            rwa_q <= 5'd0;
            it_q  <= 60'd0;
            alu_q <= 32'd0;
            rd_q  <= 32'd0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            rwa_q <= rwa_d;
            it_q  <= it_d;
            alu_q <= alu_d;
            rd_q  <= rd_d;
            err_q <= err_d;
        end
    end

    assign PC_Mem_to_WB           = pc_q;
    assign RegWriteAddr_Mem_to_WB = rwa_q;
    assign InstrType_Mem_to_WB    = it_q;
    assign ALUOut_Mem_to_WB       = alu_q;
    assign DMReadData_Mem_to_WB   = rd_q;
    assign AddrErr_Mem_to_WB      = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed load/store vectors, expected
// responses queued at issue and checked by an independent monitor.
module tb_mem_stage;

    localparam int LW = 0, SW = 1, LB = 2, LBU = 3;
    localparam int LH = 4, LHU = 5, SB = 6, SH = 7;

    logic        clk;
    logic        reset;
    logic [31:0] pc_i, alu_i, wd_i;
    logic [4:0]  rwa_i;
    logic [59:0] it_i;
    logic [31:0] pc_o, alu_o, rd_o;
    logic [4:0]  rwa_o;
    logic [59:0] it_o;
    logic        err_o;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [4:0]  rwa;
        logic [59:0] it;
        logic [31:0] alu;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] pc_ctr = 32'h400;

    mem_stage dut (
        .clk                    (clk),
        .reset                  (reset),
        .PC_EX_to_Mem           (pc_i),
        .RegWriteAddr_EX_to_Mem (rwa_i),
        .InstrType_EX_to_Mem    (it_i),
        .ALUOut_EX_to_Mem       (alu_i),
        .DMWriteData_EX_to_Mem  (wd_i),
        .PC_Mem_to_WB           (pc_o),
        .RegWriteAddr_Mem_to_WB (rwa_o),
        .InstrType_Mem_to_WB    (it_o),
        .ALUOut_Mem_to_WB       (alu_o),
        .DMReadData_Mem_to_WB   (rd_o),
        .AddrErr_Mem_to_WB      (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [59:0] bit60(int i);
        logic [59:0] v;
        v = 60'd1 << i;
        return v;
    endfunction

    task automatic issue(string tag, logic [59:0] it, logic [31:0] addr,
                         logic [31:0] wd, logic [31:0] exp_rd, logic exp_err);
        exp_t e;
        @(negedge clk);
        pc_i  = pc_ctr;
        rwa_i = pc_ctr[6:2];
        it_i  = it;
        alu_i = addr;
        wd_i  = wd;
        e.tag = tag;
        e.pc  = pc_ctr;
        e.rwa = pc_ctr[6:2];
        e.it  = it;
        e.alu = addr;
        e.rd  = exp_rd;
        e.err = exp_err;
        q.push_back(e);
        pc_ctr = pc_ctr + 32'd4;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 50) begin
            @(posedge clk);
            k++;
        end
        #2;
        check("drain", q.size(), 0);
    endtask

    task automatic check_reset(string pfx);
        check({pfx, "_pc"},  pc_o,  32'h0000_3000);
        check({pfx, "_rwa"}, rwa_o, 0);
        check({pfx, "_it"},  it_o,  0);
        check({pfx, "_alu"}, alu_o, 0);
        check({pfx, "_rd"},  rd_o,  0);
        check({pfx, "_err"}, err_o, 0);
    endtask

    // Monitor: compare every captured output against the queued expectation.
    always @(posedge clk) begin
        #1;
        if (reset && q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            check({e.tag, "_pass"}, {pc_o, rwa_o, it_o[26:0]},
                  {e.pc, e.rwa, e.it[26:0]});
            check({e.tag, "_ithi"}, it_o, e.it);
            check({e.tag, "_alu"}, alu_o, e.alu);
            check({e.tag, "_rd"}, rd_o, e.rd);
            check({e.tag, "_err"}, err_o, e.err);
        end
    end

    initial begin
        reset = 1'b0;
        pc_i  = 32'h0;
        rwa_i = 5'd0;
        it_i  = bit60(SW);
        alu_i = 32'h10;
        wd_i  = 32'h55;
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst0");
        @(negedge clk);
        it_i  = 60'd0;
        reset = 1'b1;

        issue("lw_after_rst", bit60(LW),  32'h10, 32'h0, 32'h0, 1'b0);
        issue("sw_word",      bit60(SW),  32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        issue("lw_word",      bit60(LW),  32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        issue("sb_11",        bit60(SB),  32'h11, 32'h12345680, 32'h0, 1'b0);
        issue("lb_11",        bit60(LB),  32'h11, 32'h0, 32'hFFFFFF80, 1'b0);
        issue("lbu_11",       bit60(LBU), 32'h11, 32'h0, 32'h00000080, 1'b0);
        issue("lw_after_sb",  bit60(LW),  32'h10, 32'h0, 32'hDEAD80EF, 1'b0);
        issue("sh_12",        bit60(SH),  32'h12, 32'hFFFF1234, 32'h0, 1'b0);
        issue("lh_12",        bit60(LH),  32'h12, 32'h0, 32'h00001234, 1'b0);
        issue("lw_after_sh",  bit60(LW),  32'h10, 32'h0, 32'h123480EF, 1'b0);
        issue("lhu_10",       bit60(LHU), 32'h10, 32'h0, 32'h000080EF, 1'b0);
        issue("lh_10",        bit60(LH),  32'h10, 32'h0, 32'hFFFF80EF, 1'b0);
        issue("sw_mis",       bit60(SW),  32'h13, 32'hCAFEBABE, 32'h0, 1'b1);
        issue("lw_unchanged", bit60(LW),  32'h10, 32'h0, 32'h123480EF, 1'b0);
        issue("lh_mis",       bit60(LH),  32'h11, 32'h0, 32'h0, 1'b1);
        issue("lw_mis",       bit60(LW),  32'h12, 32'h0, 32'h0, 1'b1);
        issue("lhu_mis",      bit60(LHU), 32'h13, 32'h0, 32'h0, 1'b1);
        issue("sh_mis",       bit60(SH),  32'h11, 32'hFFFF, 32'h0, 1'b1);
        issue("lb_13",        bit60(LB),  32'h13, 32'h0, 32'h00000012, 1'b0);
        issue("lw_post_mis",  bit60(LW),  32'h10, 32'h0, 32'h123480EF, 1'b0);
        issue("sw_wrap",      bit60(SW),  32'h1000, 32'hA5A5A5A5, 32'h0, 1'b0);
        issue("lw_0",         bit60(LW),  32'h0, 32'h0, 32'hA5A5A5A5, 1'b0);
        issue("lw_hi",        bit60(LW),  32'hFFFFF000, 32'h0, 32'hA5A5A5A5, 1'b0);
        issue("multihot",     bit60(SW) | bit60(LW), 32'h0, 32'h0, 32'h0, 1'b0);
        issue("lw_0_kept",    bit60(LW),  32'h0, 32'h0, 32'hA5A5A5A5, 1'b0);
        issue("zerohot",      60'd0,      32'h10, 32'h0, 32'h0, 1'b0);
        issue("other_instr",  bit60(10),  32'h10, 32'h77, 32'h0, 1'b0);
        issue("lw_end",       bit60(LW),  32'h10, 32'h0, 32'h123480EF, 1'b0);
        drain();

        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_reset("rst_mid");
        @(negedge clk);
        it_i  = 60'd0;
        reset = 1'b1;

        issue("lw_0_clr",  bit60(LW), 32'h0,  32'h0, 32'h0, 1'b0);
        issue("lw_10_clr", bit60(LW), 32'h10, 32'h0, 32'h0, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DM_WORDS, default 1024: number of 32-bit data-memory words; the word index is ALUOut_EX_to_Mem[11:2].
REQ-002 Parameters IDX_LW, IDX_SW, IDX_LB, IDX_LBU, IDX_LH, IDX_LHU, IDX_SB, IDX_SH, defaults 0..7: bit positions of each memory instruction within the one-hot InstrType bus.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 PC_EX_to_Mem  input  32  PC of the instruction in Mem.
REQ-006 RegWriteAddr_EX_to_Mem  input  5  GPR write-back address.
REQ-007 InstrType_EX_to_Mem  input  60  one-hot instruction type.
REQ-008 ALUOut_EX_to_Mem  input  32  ALU result, used as the effective address for loads and stores.
REQ-009 DMWriteData_EX_to_Mem  input  32  store data (rt value).
REQ-010 PC_Mem_to_WB  output  32  registered PC.
REQ-011 RegWriteAddr_Mem_to_WB  output  5  registered write address.
REQ-012 InstrType_Mem_to_WB  output  60  registered instruction type.
REQ-013 ALUOut_Mem_to_WB  output  32  registered ALU result.
REQ-014 DMReadData_Mem_to_WB  output  32  registered, extended load result.
REQ-015 AddrErr_Mem_to_WB  output  1  registered misaligned-access flag.

Function
REQ-016 Every output SHALL be a flop updated on posedge clk, giving a one-cycle latency from inputs to outputs.
REQ-017 PC, RegWriteAddr, InstrType and ALUOut SHALL pass unchanged to their _Mem_to_WB registers.
REQ-018 DM SHALL be a DM_WORDS x 32 array; reads SHALL be combinational from the current address; writes SHALL occur on posedge clk.
REQ-019 Alignment rules SHALL be as follows:
- sw, lw: misaligned when addr[1:0]!=0.
- sh, lh, lhu: misaligned when addr[0]!=0.
REQ-020 A misaligned store SHALL write nothing; a misaligned access SHALL set AddrErr_Mem_to_WB=1 for that cycle, otherwise it is 0.
REQ-021 Stores SHALL write only the addressed bytes:
- sw: all four bytes.
- sh: byte lanes {addr[1],0} and {addr[1],1} take data[15:0].
- sb: byte lane addr[1:0] takes data[7:0].
- All other bytes are untouched.
REQ-022 Loads SHALL select and extend the addressed data:
- lw: the whole word.
- lb/lbu: byte addr[1:0], sign-extended or zero-extended.
- lh/lhu: halfword addr[1], sign-extended or zero-extended.
REQ-023 For non-load instructions and misaligned loads, DMReadData_Mem_to_WB SHALL be 0.
REQ-024 A load that follows a store to the same word SHALL return the stored data, because the write completes at the edge before the load's read.
REQ-025 Address bits [31:12] SHALL be ignored; the address wraps modulo the DM size.
REQ-026 If InstrType has zero bits set or multiple bits set, no write SHALL occur and DMReadData SHALL be 0.

Reset
REQ-027 While reset is low, regardless of clk, the following SHALL hold:
- PC_Mem_to_WB = 0x0000_3000.
- All other outputs = 0.
- Every DM word = 0.
REQ-028 A store coinciding with reset assertion SHALL be discarded.
REQ-029 The first posedge after reset deasserts SHALL capture inputs normally.

Verification
REQ-030 Reset: pulse reset low mid-cycle with the outputs nonzero -> all outputs change immediately to their reset values (PC 0x3000), and lw of 0x0 afterwards returns 0.
REQ-031 Word: sw 0xDEADBEEF @0x10, then lw @0x10 -> DMReadData 0xDEADBEEF one cycle after the lw.
REQ-032 Byte/half: after the word above, sb 0x80 @0x11, then:
- lb @0x11 -> 0xFFFFFF80.
- lbu @0x11 -> 0x00000080.
- lw @0x10 -> 0xDEAD80EF.
REQ-033 Half: sh 0x1234 @0x12, then lh @0x12 -> 0x00001234 and lw @0x10 -> 0x123480EF.
REQ-034 Misaligned: sw @0x13 -> AddrErr=1 and memory unchanged; lh @0x11 -> AddrErr=1 and DMReadData=0.
REQ-035 Wrap: sw 0xA5A5A5A5 @0x1000, then lw @0x0 -> 0xA5A5A5A5; passthrough fields match the inputs delayed by one cycle.
